// File: rtl/pixel_serialiser.sv
// Double-buffered video byte serialiser: turns fetched bytes into per-pixel
// 4-bit palette indices under VDG-style text/SG4/graphics mode control.
module pixel_serialiser #(
    parameter logic [3:0] UNDERFLOW_INDEX = 4'd0,
    parameter bit         TEXT_BG_DARK    = 1'b1
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       pixelEn,
    input  logic [7:0] dataIn,
    input  logic       dataValid,
    output logic       dataReady,
    input  logic       ag,
    input  logic       sg,
    input  logic       gm0,
    input  logic       css,
    input  logic       inv,
    input  logic       rowHalf,
    input  logic       borderActive,
    input  logic       clrUnderflow,
    output logic [3:0] colourIndex,
    output logic       underflow
);

    typedef enum logic [1:0] {
        MODE_TEXT = 2'd0,
        MODE_SG4  = 2'd1,
        MODE_CG   = 2'd2,
        MODE_RG   = 2'd3
    } mode_t;

    logic [7:0] holdReg, holdRegNx;
    logic       holdFull, holdFullNx;
    logic [7:0] shiftReg, shiftRegNx;
    mode_t      latMode, latModeNx;
    logic       latCss, latCssNx;
    logic       latInv, latInvNx;
    logic       latRow, latRowNx;
    logic       active, activeNx;
    logic [2:0] pixCount, pixCountNx;
    logic [3:0] colourNx;
    logic       underflowNx;
    logic       starved;
    mode_t      liveMode;

    function automatic logic [3:0] pix_index(input logic [7:0] b, input logic [2:0] p,
                                             input mode_t m, input logic c,
                                             input logic iv, input logic rh);
        logic       t;
        logic       q;
        logic [1:0] pair;
        logic [3:0] r;
        r = 4'd0;
        case (m)
            MODE_TEXT: begin
                t = b[3'd7 - p] ^ iv;
                if (t)
                    r = c ? 4'd8 : 4'd1;
                else if (TEXT_BG_DARK)
                    r = c ? 4'd11 : 4'd10;
                else
                    r = 4'd0;
            end
            MODE_SG4: begin
                q = rh ? (p[2] ? b[0] : b[1]) : (p[2] ? b[2] : b[3]);
                r = q ? ({1'b0, b[6:4]} + 4'd1) : 4'd0;
            end
            MODE_CG: begin
                // each 2-bit pair covers two adjacent pixel slots
                pair = b[3'd7 - {p[2:1], 1'b0} -: 2];
                r    = {1'b0, c, pair} + 4'd1;
            end
            default: begin
                r = b[3'd7 - p] ? (c ? 4'd5 : 4'd1) : 4'd0;
            end
        endcase
        return r;
    endfunction

    assign dataReady = ~holdFull;
    assign liveMode  = ag ? (gm0 ? MODE_RG : MODE_CG) : (sg ? MODE_SG4 : MODE_TEXT);

    always_comb begin
        holdRegNx  = holdReg;
        holdFullNx = holdFull;
        shiftRegNx = shiftReg;
        latModeNx  = latMode;
        latCssNx   = latCss;
        latInvNx   = latInv;
        latRowNx   = latRow;
        activeNx   = active;
        pixCountNx = pixCount;
        colourNx   = colourIndex;
        starved    = 1'b0;

        // write needs empty, consume needs full, so the two never collide
        if (dataValid && !holdFull) begin
            holdRegNx  = dataIn;
            holdFullNx = 1'b1;
        end

        if (pixelEn) begin
            if (borderActive) begin
                colourNx   = ag ? (css ? 4'd5 : 4'd1) : 4'd0;
                activeNx   = 1'b0;
                pixCountNx = 3'd0;
            end else if (!active || pixCount == 3'd7) begin
                if (holdFull) begin
                    shiftRegNx = holdReg;
                    latModeNx  = liveMode;
                    latCssNx   = css;
                    latInvNx   = inv;
                    latRowNx   = rowHalf;
                    holdFullNx = 1'b0;
                    activeNx   = 1'b1;
                    pixCountNx = 3'd0;
                    colourNx   = pix_index(holdReg, 3'd0, liveMode, css, inv, rowHalf);
                end else begin
                    colourNx = UNDERFLOW_INDEX;
                    activeNx = 1'b0;
                    starved  = 1'b1;
                end
            end else begin
                pixCountNx = pixCount + 3'd1;
                colourNx   = pix_index(shiftReg, pixCount + 3'd1, latMode, latCss, latInv, latRow);
            end
        end

        underflowNx = starved ? 1'b1 : (clrUnderflow ? 1'b0 : underflow);
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            holdReg     <= '0;
            holdFull    <= 1'b0;
            shiftReg    <= '0;
            latMode     <= MODE_TEXT;
            latCss      <= 1'b0;
            latInv      <= 1'b0;
            latRow      <= 1'b0;
            active      <= 1'b0;
            pixCount    <= '0;
            colourIndex <= '0;
            underflow   <= 1'b0;
        end else begin
            holdReg     <= holdRegNx;
            holdFull    <= holdFullNx;
            shiftReg    <= shiftRegNx;
            latMode     <= latModeNx;
            latCss      <= latCssNx;
            latInv      <= latInvNx;
            latRow      <= latRowNx;
            active      <= activeNx;
            pixCount    <= pixCountNx;
            colourIndex <= colourNx;
            underflow   <= underflowNx;
        end
    end

endmodule
